// File: rtl/cache_controller.sv
// 2-way set-associative write-through, no-write-allocate data cache, one word per line.
// Latency: read hit 0 cycles; read miss and all writes wait for the SRAM controller's ready pulse.
// Backpressure: o_ready low freezes the MEM stage; requests must be held stable until o_ready.
module cache_controller #(
  parameter int INDEX_W     = 6,
  parameter int ADDR_OFFSET = 1024,
  parameter int WA_W        = 17
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_mem_r_en,
  input  logic        i_mem_w_en,
  input  logic [31:0] i_address,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata,
  output logic        o_ready,
  output logic        o_sram_read_en,
  output logic        o_sram_write_en,
  output logic [31:0] o_sram_address,
  output logic [31:0] o_sram_wdata,
  input  logic [31:0] i_sram_rdata,
  input  logic        i_sram_ready
);

  localparam int SETS  = 2 ** INDEX_W;
  localparam int TAG_W = WA_W - INDEX_W;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_READ_MISS = 2'd1,
    S_WRITE     = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next_state;

  logic r_sram_read_en;
  logic r_sram_write_en;

  // Per-set storage: valid and lru bits are reset, tags/data are not.
  logic [SETS-1:0]  r_valid0;
  logic [SETS-1:0]  r_valid1;
  logic [SETS-1:0]  r_lru;
  logic [TAG_W-1:0] r_tag0  [SETS];
  logic [TAG_W-1:0] r_tag1  [SETS];
  logic [31:0]      r_data0 [SETS];
  logic [31:0]      r_data1 [SETS];

  logic [WA_W-1:0]    w_wa;
  logic [INDEX_W-1:0] w_index;
  logic [TAG_W-1:0]   w_tag;
  logic               w_hit0;
  logic               w_hit1;
  logic               w_victim;

  logic w_lru_we;
  logic w_lru_val;
  logic w_fill;
  logic w_wr0;
  logic w_wr1;

  // Word address relative to the data-memory base; upper bits beyond WA_W are dropped.
  assign w_wa    = WA_W'((i_address - 32'(ADDR_OFFSET)) >> 2);
  assign w_index = w_wa[INDEX_W-1:0];
  assign w_tag   = w_wa[WA_W-1:INDEX_W];

  assign w_hit0 = r_valid0[w_index] & (r_tag0[w_index] == w_tag);
  assign w_hit1 = r_valid1[w_index] & (r_tag1[w_index] == w_tag);

  // Prefer an empty way; only fall back to lru when both ways hold data.
  assign w_victim = !r_valid0[w_index] ? 1'b0 :
                    !r_valid1[w_index] ? 1'b1 : r_lru[w_index];

  assign o_sram_address  = i_address;
  assign o_sram_wdata    = i_wdata;
  assign o_sram_read_en  = r_sram_read_en;
  assign o_sram_write_en = r_sram_write_en;

  // Next-state, handshake outputs and cache-update strobes.
  always_comb begin
    w_next_state = r_state;
    o_ready      = 1'b0;
    o_rdata      = 32'd0;
    w_lru_we     = 1'b0;
    w_lru_val    = 1'b0;
    w_fill       = 1'b0;
    w_wr0        = 1'b0;
    w_wr1        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_mem_w_en) begin
          w_next_state = S_WRITE;
        end else if (i_mem_r_en) begin
          if (w_hit0 || w_hit1) begin
            o_ready   = 1'b1;
            o_rdata   = w_hit0 ? r_data0[w_index] : r_data1[w_index];
            w_lru_we  = 1'b1;
            w_lru_val = w_hit0;
          end else begin
            w_next_state = S_READ_MISS;
          end
        end else begin
          o_ready = 1'b1;
        end
      end
      S_READ_MISS: begin
        if (i_sram_ready) begin
          o_ready      = 1'b1;
          o_rdata      = i_mem_r_en ? i_sram_rdata : 32'd0;
          w_fill       = 1'b1;
          w_lru_we     = 1'b1;
          w_lru_val    = ~w_victim;
          w_next_state = S_IDLE;
        end
      end
      S_WRITE: begin
        if (i_sram_ready) begin
          o_ready      = 1'b1;
          w_wr0        = w_hit0;
          w_wr1        = w_hit1 & ~w_hit0;
          w_lru_we     = w_hit0 | w_hit1;
          w_lru_val    = w_hit0;
          w_next_state = S_IDLE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // State register; SRAM enables are registered copies of the next state.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state         <= S_IDLE;
      r_sram_read_en  <= 1'b0;
      r_sram_write_en <= 1'b0;
    end else begin
      r_state         <= w_next_state;
      r_sram_read_en  <= (w_next_state == S_READ_MISS);
      r_sram_write_en <= (w_next_state == S_WRITE);
    end
  end

  // Valid and lru bookkeeping; reset invalidates every line and discards any in-flight fill.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_valid0 <= '0;
      r_valid1 <= '0;
      r_lru    <= '0;
    end else begin
      if (w_fill) begin
        if (w_victim) r_valid1[w_index] <= 1'b1;
        else          r_valid0[w_index] <= 1'b1;
      end
      if (w_lru_we) r_lru[w_index] <= w_lru_val;
    end
  end

  // Tag/data arrays: line fill on read miss, in-place update on write hit.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      if (w_fill) begin
        if (w_victim) begin
          r_tag1[w_index]  <= w_tag;
          r_data1[w_index] <= i_sram_rdata;
        end else begin
          r_tag0[w_index]  <= w_tag;
          r_data0[w_index] <= i_sram_rdata;
        end
      end
      if (w_wr0) r_data0[w_index] <= i_wdata;
      if (w_wr1) r_data1[w_index] <= i_wdata;
    end
  end

endmodule

// File: tb/tb_cache_controller.sv
// Randomized bench for cache_controller with a behavioural cache/memory model and an SRAM responder.
// Each request is checked for cycle count, SRAM enable usage, address pass-through and read data.
// The SRAM responder raises sram_ready 5 cycles after an enable rises, for one cycle.
module tb_cache_controller;

  localparam int SETS = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_r_en;
  logic        mem_w_en;
  logic [31:0] address;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic        sram_read_en;
  logic        sram_write_en;
  logic [31:0] sram_address;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;
  logic        sram_ready;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  cache_controller dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_mem_r_en      (mem_r_en),
    .i_mem_w_en      (mem_w_en),
    .i_address       (address),
    .i_wdata         (wdata),
    .o_rdata         (rdata),
    .o_ready         (ready),
    .o_sram_read_en  (sram_read_en),
    .o_sram_write_en (sram_write_en),
    .o_sram_address  (sram_address),
    .o_sram_wdata    (sram_wdata),
    .i_sram_rdata    (sram_rdata),
    .i_sram_ready    (sram_ready)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Background memory contents for never-written words.
  function automatic logic [31:0] mem_init(input int wa);
    return (wa * 32'h9E37_79B1) ^ 32'h1357_2468;
  endfunction

  // ---------------- SRAM responder (environment, driven by DUT outputs) ----------------
  logic [31:0] sram_mem [int];
  int          sram_cnt = 0;

  function automatic logic [31:0] sram_rd(input int wa);
    return sram_mem.exists(wa) ? sram_mem[wa] : mem_init(wa);
  endfunction

  initial begin
    sram_ready = 1'b0;
    sram_rdata = 32'd0;
    forever begin
      @(posedge clk);
      #1;
      if (sram_read_en || sram_write_en) sram_cnt++;
      else                               sram_cnt = 0;
      if ((sram_read_en || sram_write_en) && sram_cnt == 6) begin
        int wa;
        wa = int'((sram_address - 32'd1024) >> 2);
        sram_ready = 1'b1;
        sram_rdata = sram_read_en ? sram_rd(wa) : $urandom;
        if (sram_write_en) sram_mem[wa] = sram_wdata;
      end else begin
        sram_ready = 1'b0;
        sram_rdata = $urandom;
      end
    end
  end

  // ---------------- Behavioural reference model ----------------
  bit          m_valid [SETS][2];
  int          m_tag   [SETS][2];
  logic [31:0] m_data  [SETS][2];
  bit          m_lru   [SETS];
  logic [31:0] exp_mem [int];

  function automatic logic [31:0] exp_rd(input int wa);
    return exp_mem.exists(wa) ? exp_mem[wa] : mem_init(wa);
  endfunction

  function automatic void model_reset();
    for (int s = 0; s < SETS; s++) begin
      m_valid[s][0] = 1'b0;
      m_valid[s][1] = 1'b0;
      m_lru[s]      = 1'b0;
    end
  endfunction

  // One complete request, presented at posedge+2 and held until ready.
  task automatic do_req(input bit w, input bit r, input int wa, input logic [31:0] wd, input string tag);
    int          set_i, tag_i, hit_way, exp_cyc, exp_rdc, exp_wrc;
    int          cyc, rdc, wrc, both;
    bit          done, chk_rd;
    logic [31:0] exp_data, got_data, addr_seen;
    set_i   = wa % SETS;
    tag_i   = wa / SETS;
    hit_way = -1;
    for (int k = 1; k >= 0; k--)
      if (m_valid[set_i][k] && m_tag[set_i][k] == tag_i) hit_way = k;
    chk_rd   = 1'b0;
    exp_data = 32'd0;
    if (w) begin
      exp_cyc = 7; exp_rdc = 0; exp_wrc = 6;
    end else if (hit_way >= 0) begin
      exp_cyc = 1; exp_rdc = 0; exp_wrc = 0; chk_rd = 1'b1;
      exp_data = m_data[set_i][hit_way];
    end else begin
      exp_cyc = 7; exp_rdc = 6; exp_wrc = 0; chk_rd = 1'b1;
      exp_data = exp_rd(wa);
    end

    address  = 32'd1024 + 32'(wa) * 32'd4;
    wdata    = wd;
    mem_w_en = w;
    mem_r_en = r;
    cyc = 0; rdc = 0; wrc = 0; both = 0; done = 1'b0;
    got_data = 32'd0; addr_seen = 32'd0;
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (sram_read_en)                  rdc++;
      if (sram_write_en)                 wrc++;
      if (sram_read_en && sram_write_en) both++;
      if (ready) begin
        done      = 1'b1;
        got_data  = rdata;
        addr_seen = sram_address;
      end
      @(posedge clk);
      #2;
    end
    mem_w_en = 1'b0;
    mem_r_en = 1'b0;

    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_cycles"}, 32'(cyc), 32'(exp_cyc));
    chk({tag, "_rd_en_cycles"}, 32'(rdc), 32'(exp_rdc));
    chk({tag, "_wr_en_cycles"}, 32'(wrc), 32'(exp_wrc));
    chk({tag, "_en_overlap"}, 32'(both), 32'd0);
    chk({tag, "_sram_addr"}, addr_seen, 32'd1024 + 32'(wa) * 32'd4);
    if (chk_rd) chk({tag, "_rdata"}, got_data, exp_data);

    if (w) begin
      exp_mem[wa] = wd;
      if (hit_way >= 0) begin
        m_data[set_i][hit_way] = wd;
        m_lru[set_i] = (hit_way == 0);
      end
    end else if (hit_way >= 0) begin
      m_lru[set_i] = (hit_way == 0);
    end else begin
      int v;
      v = !m_valid[set_i][0] ? 0 : (!m_valid[set_i][1] ? 1 : int'(m_lru[set_i]));
      m_valid[set_i][v] = 1'b1;
      m_tag[set_i][v]   = tag_i;
      m_data[set_i][v]  = exp_data;
      m_lru[set_i]      = (v == 0);
    end
  endtask

  task automatic pulse_reset(input string tag);
    rst      = 1'b1;
    mem_r_en = 1'b0;
    mem_w_en = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    chk({tag, "_ready"}, 32'(ready), 32'd1);
    chk({tag, "_rd_en"}, 32'(sram_read_en), 32'd0);
    chk({tag, "_wr_en"}, 32'(sram_write_en), 32'd0);
    chk({tag, "_rdata_idle"}, rdata, 32'd0);
    @(posedge clk);
    #2;
  endtask

  // Global time limit so the run always ends.
  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- Main stimulus ----------------
  initial begin
    int top_wa;
    rst      = 1'b1;
    mem_r_en = 1'b0;
    mem_w_en = 1'b0;
    address  = 32'd1024;
    wdata    = 32'd0;
    model_reset();
    top_wa = (1 << 17) - 1;

    pulse_reset("reset");

    // Cold read then re-read of the base address.
    do_req(0, 1, 0, 32'd0, "t1_cold");
    do_req(0, 1, 0, 32'd0, "t1_hit");

    // Write hit updates the line; write miss only goes to memory.
    do_req(1, 0, 0, 32'hDEAD_BEEF, "t2_wr_hit");
    do_req(0, 1, 0, 32'd0, "t2_rd_after_wr");
    do_req(1, 0, 256, 32'hCAFE_F00D, "t2_wr_miss");
    do_req(0, 1, 256, 32'd0, "t2_rd_miss");

    // Set-0 conflicts with a clean cache.
    pulse_reset("t3_reset");
    do_req(0, 1, 0,   32'd0, "t3_a");
    do_req(0, 1, 64,  32'd0, "t3_b");
    do_req(0, 1, 0,   32'd0, "t3_a_hit");
    do_req(0, 1, 128, 32'd0, "t3_c_evict");
    do_req(0, 1, 0,   32'd0, "t3_a_still");
    do_req(0, 1, 64,  32'd0, "t3_b_gone");

    // Both enables: handled as a write, no fill.
    do_req(1, 1, 300, 32'h1234_5678, "t4_both");
    do_req(0, 1, 300, 32'd0, "t4_rd_miss");

    // Reset two cycles into a read miss.
    do_req(0, 1, 0, 32'd0, "t5_prehit");
    address  = 32'd1024 + 32'd4 * 32'd777;
    mem_r_en = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    rst      = 1'b1;
    mem_r_en = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    chk("t5_ready_after_rst", 32'(ready), 32'd1);
    chk("t5_rd_en_after_rst", 32'(sram_read_en), 32'd0);
    chk("t5_wr_en_after_rst", 32'(sram_write_en), 32'd0);
    @(posedge clk);
    #2;
    do_req(0, 1, 0, 32'd0, "t5_now_miss");

    // Top word address: set 63, all-ones tag; base address stays distinct.
    do_req(0, 1, top_wa, 32'd0, "t6_top_fill");
    do_req(0, 1, top_wa, 32'd0, "t6_top_hit");
    do_req(1, 0, top_wa, 32'hA5A5_5A5A, "t6_top_wr");
    do_req(0, 1, 0, 32'd0, "t6_base");
    do_req(0, 1, top_wa, 32'd0, "t6_top_hit2");

    // Random traffic over a small pool of conflicting word addresses.
    for (int i = 0; i < 300; i++) begin
      int sel_set, sel_tag, wa, op;
      sel_set = $urandom_range(0, 2);
      sel_tag = $urandom_range(0, 3);
      wa = (sel_tag == 3 ? 2047 : sel_tag) * SETS + (sel_set == 2 ? 63 : sel_set);
      op = $urandom_range(0, 19);
      if (op < 11)      do_req(0, 1, wa, 32'd0, "rnd_rd");
      else if (op < 18) do_req(1, 0, wa, $urandom, "rnd_wr");
      else              do_req(1, 1, wa, $urandom, "rnd_both");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
